// File: rtl/iencoder.sv
// RV32I instruction encoder: decoded fields in, 32-bit instruction words out through a small FIFO.
// Optional build macro IENCODER_RANGE_CHECK_EN flags immediates that do not fit their instruction format.

`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 4
`endif
`ifndef FUNCT_WIDTH
`define FUNCT_WIDTH 5
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif
`ifndef IMM_WIDTH
`define IMM_WIDTH 32
`endif

`ifndef INST_TYPE_IMM
`define INST_TYPE_IMM     4'd0
`define INST_TYPE_AUIPC   4'd1
`define INST_TYPE_JAL     4'd2
`define INST_TYPE_JALR    4'd3
`define INST_TYPE_INT_IMM 4'd4
`define INST_TYPE_INT_REG 4'd5
`define INST_TYPE_BRANCH  4'd6
`define INST_TYPE_STORE   4'd7
`define INST_TYPE_LOAD    4'd8
`define INST_TYPE_FENCE   4'd9
`endif

`ifndef FUNCT_ADD
`define FUNCT_ADD        5'd0
`define FUNCT_SUB        5'd1
`define FUNCT_SLL        5'd2
`define FUNCT_SLT        5'd3
`define FUNCT_SLTU       5'd4
`define FUNCT_XOR        5'd5
`define FUNCT_SRL        5'd6
`define FUNCT_SRA        5'd7
`define FUNCT_OR         5'd8
`define FUNCT_AND        5'd9
`define FUNCT_BR_EQ      5'd10
`define FUNCT_BR_NEQ     5'd11
`define FUNCT_BR_LT      5'd12
`define FUNCT_BR_GTE     5'd13
`define FUNCT_BR_LTU     5'd14
`define FUNCT_BR_GTEU    5'd15
`define FUNCT_MEM_BYTE   5'd16
`define FUNCT_MEM_HWORD  5'd17
`define FUNCT_MEM_WORD   5'd18
`define FUNCT_MEM_BYTEU  5'd19
`define FUNCT_MEM_HWORDU 5'd20
`endif

module iencoder #(
  parameter int FIFO_DEPTH  = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [`INST_TYPE_WIDTH-1:0] in_inst_type,
  input  logic [`FUNCT_WIDTH-1:0]     in_funct,
  input  logic [`REG_WIDTH-1:0]       in_rd,
  input  logic [`REG_WIDTH-1:0]       in_rs1,
  input  logic [`REG_WIDTH-1:0]       in_rs2,
  input  logic [`IMM_WIDTH-1:0]       in_imm,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [`INST_WIDTH-1:0]      out_inst,
  output logic                        out_error,
  output logic [COUNT_WIDTH-1:0]      enc_count,
  output logic [COUNT_WIDTH-1:0]      err_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_INTIMM = 7'b0010011;
  localparam logic [6:0] OP_INTREG = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [31:0] FENCE_WORD = 32'h0FF0000F;

  typedef enum logic [2:0] {FMT_I, FMT_SH, FMT_R, FMT_S, FMT_B, FMT_U, FMT_J, FMT_FIX} fmt_e;

  // Immediate range violations; constant zero when range checking is compiled out.
  logic bad_i, bad_b, bad_j, bad_sh, bad_u;
`ifdef IENCODER_RANGE_CHECK_EN
  assign bad_i  = (in_imm[31:11] != {21{in_imm[11]}});
  assign bad_b  = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
  assign bad_j  = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
  assign bad_sh = (in_imm[31:5] != '0);
  assign bad_u  = (in_imm[11:0] != '0);
`else
  assign bad_i  = 1'b0;
  assign bad_b  = 1'b0;
  assign bad_j  = 1'b0;
  assign bad_sh = 1'b0;
  assign bad_u  = 1'b0;
`endif

  fmt_e        fmt;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        bad_funct;
  logic        enc_illegal;
  logic [31:0] enc_inst;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fmt       = FMT_I;
    opc       = 7'd0;
    f3        = 3'd0;
    f7        = 7'd0;
    bad_funct = 1'b0;
    case (in_inst_type)
      `INST_TYPE_IMM:   begin fmt = FMT_U; opc = OP_LUI;   end
      `INST_TYPE_AUIPC: begin fmt = FMT_U; opc = OP_AUIPC; end
      `INST_TYPE_JAL:   begin fmt = FMT_J; opc = OP_JAL;   end
      `INST_TYPE_JALR:  begin fmt = FMT_I; opc = OP_JALR;  end
      `INST_TYPE_FENCE: fmt = FMT_FIX;
      `INST_TYPE_INT_IMM, `INST_TYPE_INT_REG: begin
        fmt = (in_inst_type == `INST_TYPE_INT_REG) ? FMT_R : FMT_I;
        opc = (in_inst_type == `INST_TYPE_INT_REG) ? OP_INTREG : OP_INTIMM;
        case (in_funct)
          `FUNCT_ADD:  f3 = 3'd0;
          `FUNCT_SUB: begin
            f3 = 3'd0; f7 = 7'b0100000;
            bad_funct = (in_inst_type == `INST_TYPE_INT_IMM);
          end
          `FUNCT_SLL:  begin f3 = 3'd1; if (fmt == FMT_I) fmt = FMT_SH; end
          `FUNCT_SLT:  f3 = 3'd2;
          `FUNCT_SLTU: f3 = 3'd3;
          `FUNCT_XOR:  f3 = 3'd4;
          `FUNCT_SRL:  begin f3 = 3'd5; if (fmt == FMT_I) fmt = FMT_SH; end
          `FUNCT_SRA: begin
            f3 = 3'd5; f7 = 7'b0100000;
            if (fmt == FMT_I) fmt = FMT_SH;
          end
          `FUNCT_OR:   f3 = 3'd6;
          `FUNCT_AND:  f3 = 3'd7;
          default:     bad_funct = 1'b1;
        endcase
      end
      `INST_TYPE_BRANCH: begin
        fmt = FMT_B; opc = OP_BRANCH;
        case (in_funct)
          `FUNCT_BR_EQ:   f3 = 3'd0;
          `FUNCT_BR_NEQ:  f3 = 3'd1;
          `FUNCT_BR_LT:   f3 = 3'd4;
          `FUNCT_BR_GTE:  f3 = 3'd5;
          `FUNCT_BR_LTU:  f3 = 3'd6;
          `FUNCT_BR_GTEU: f3 = 3'd7;
          default:        bad_funct = 1'b1;
        endcase
      end
      `INST_TYPE_STORE, `INST_TYPE_LOAD: begin
        fmt = (in_inst_type == `INST_TYPE_STORE) ? FMT_S : FMT_I;
        opc = (in_inst_type == `INST_TYPE_STORE) ? OP_STORE : OP_LOAD;
        case (in_funct)
          `FUNCT_MEM_BYTE:   f3 = 3'd0;
          `FUNCT_MEM_HWORD:  f3 = 3'd1;
          `FUNCT_MEM_WORD:   f3 = 3'd2;
          `FUNCT_MEM_BYTEU: begin f3 = 3'd4; bad_funct = (fmt == FMT_S); end
          `FUNCT_MEM_HWORDU: begin f3 = 3'd5; bad_funct = (fmt == FMT_S); end
          default:           bad_funct = 1'b1;
        endcase
      end
      default: bad_funct = 1'b1;
    endcase
  end

  always_comb begin
    enc_inst    = '0;
    enc_illegal = bad_funct;
    case (fmt)
      FMT_I: begin
        enc_inst = {in_imm[11:0], in_rs1, f3, in_rd, opc};
        enc_illegal = enc_illegal | bad_i;
      end
      FMT_SH: begin
        enc_inst = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
        enc_illegal = enc_illegal | bad_sh;
      end
      FMT_R: enc_inst = {f7, in_rs2, in_rs1, f3, in_rd, opc};
      FMT_S: begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
        enc_illegal = enc_illegal | bad_i;
      end
      FMT_B: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
        enc_illegal = enc_illegal | bad_b;
      end
      FMT_U: begin
        enc_inst = {in_imm[31:12], in_rd, opc};
        enc_illegal = enc_illegal | bad_u;
      end
      FMT_J: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
        enc_illegal = enc_illegal | bad_j;
      end
      default: enc_inst = FENCE_WORD;
    endcase
    if (enc_illegal) enc_inst = '0;
  end

  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          ready_q;
  logic          push, pop;

  assign in_ready  = ready_q;
  assign out_valid = (count != '0);
  assign push      = in_valid & ready_q;
  assign pop       = out_valid & out_ready;
  assign out_inst  = out_valid ? mem[rd_ptr][31:0] : '0;
  assign out_error = out_valid & mem[rd_ptr][32];

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (!push && pop) count_next = count - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ready_q   <= 1'b0;
      enc_count <= '0;
      err_count <= '0;
    end else begin
      count   <= count_next;
      ready_q <= (count_next < CW'(FIFO_DEPTH));
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (enc_count != '1) enc_count <= enc_count + COUNT_WIDTH'(1);
        if (enc_illegal && err_count != '1) err_count <= err_count + COUNT_WIDTH'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // NOTE: storage is not reset; entries are only observed through out_valid, which comes from the reset occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {enc_illegal, enc_inst};
  end

endmodule
